ps_window_accum: RTL and testbench

//   Downstream of ps_comp_unit. Sums its per-sample power values (dout/data_valid) over a fixed

---
 rtl/ps_window_accum.sv | 128 ++++++++++++
 tb/tb_ps_window_accum.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_window_accum.sv
// ps_window_accum
//   Sums unsigned power samples over windows of WINDOW_LEN accepted samples
//   and presents one saturating window sum per window in a valid/ready output
//   register, together with a threshold-detect flag and a sticky overrun flag.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   en                accumulate enable (low pauses the window)
//   clear             synchronous restart of the current window, clears overrun
//   din, din_valid    input power sample and qualifier
//   dout, dout_valid  window sum and its valid flag
//   dout_ready        consumer accept for dout
//   sat               window sum saturated
//   detect            window sum > THRESH
//   overrun           sticky: a window result replaced an unconsumed one
module ps_window_accum #(
  parameter int unsigned             INPUT_WIDTH  = 32,
  parameter int unsigned             OUTPUT_WIDTH = 40,
  parameter int unsigned             WINDOW_LEN   = 256,
  parameter int unsigned             CNT_WIDTH    = 8,
  parameter logic [OUTPUT_WIDTH-1:0] THRESH       = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic [INPUT_WIDTH-1:0]  din,
  input  logic                    din_valid,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    sat,
  output logic                    detect,
  output logic                    overrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW_LEN - 1);

  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    acc_sat_q, acc_sat_d;
  logic [OUTPUT_WIDTH-1:0] dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    sat_q, sat_d;
  logic                    detect_q, detect_d;
  logic                    overrun_q, overrun_d;

  logic                    acc_en;
  logic                    win_end;
  logic [OUTPUT_WIDTH:0]   sum_ext;
  logic                    sat_this_add;
  logic [OUTPUT_WIDTH-1:0] acc_next;

  // One extra carry bit detects overflow of the saturating add.
  always_comb begin
    acc_en       = din_valid & en & ~clear;
    win_end      = acc_en & (cnt_q == CNT_LAST);
    sum_ext      = {1'b0, acc_q} + {{(OUTPUT_WIDTH + 1 - INPUT_WIDTH){1'b0}}, din};
    sat_this_add = sum_ext[OUTPUT_WIDTH];
    acc_next     = sat_this_add ? '1 : sum_ext[OUTPUT_WIDTH-1:0];
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    acc_sat_d    = acc_sat_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    sat_d        = sat_q;
    detect_d     = detect_q;
    overrun_d    = overrun_q;

    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      acc_sat_d = 1'b0;
      overrun_d = 1'b0;
    end else if (win_end) begin
      acc_d     = '0;
      cnt_d     = '0;
      acc_sat_d = 1'b0;
    end else if (acc_en) begin
      acc_d     = acc_next;
      cnt_d     = cnt_q + CNT_WIDTH'(1);
      acc_sat_d = acc_sat_q | sat_this_add;
    end

    // A window ending in the same cycle as a consumer accept reloads the
    // register and keeps dout_valid high; only an unaccepted result overruns.
    if (win_end) begin
      dout_d       = acc_next;
      sat_d        = acc_sat_q | sat_this_add;
      detect_d     = acc_next > THRESH;
      dout_valid_d = 1'b1;
      if (dout_valid_q & ~dout_ready) overrun_d = 1'b1;
    end else if (dout_valid_q & dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      acc_sat_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      detect_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      acc_sat_q    <= acc_sat_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
      detect_q     <= detect_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;
  assign detect     = detect_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps_window_accum.sv
// tb_ps_window_accum
//   Two instances share stimulus: A is the 40-bit accumulator build, B the
//   32-bit build that exercises saturation. Both are compared every cycle
//   against a window-sum reference model, plus table and directed checks.
module tb_ps_window_accum;

  localparam int unsigned WL = 4;
  localparam longint unsigned TH = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        dout_ready = 1'b1;

  logic [39:0] a_dout;
  logic        a_valid, a_sat, a_det, a_ovr;
  logic [31:0] b_dout;
  logic        b_valid, b_sat, b_det, b_ovr;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ps_window_accum #(
    .INPUT_WIDTH(32), .OUTPUT_WIDTH(40), .WINDOW_LEN(4), .CNT_WIDTH(2),
    .THRESH(40'd100)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .din(din), .din_valid(din_valid),
    .dout(a_dout), .dout_valid(a_valid), .dout_ready(dout_ready),
    .sat(a_sat), .detect(a_det), .overrun(a_ovr)
  );

  ps_window_accum #(
    .INPUT_WIDTH(32), .OUTPUT_WIDTH(32), .WINDOW_LEN(4), .CNT_WIDTH(2),
    .THRESH(32'd100)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .din(din), .din_valid(din_valid),
    .dout(b_dout), .dout_valid(b_valid), .dout_ready(dout_ready),
    .sat(b_sat), .detect(b_det), .overrun(b_ovr)
  );

  // Reference model: accepted samples summed as plain integers, result
  // clipped to each build's width when the window completes.
  longint unsigned m_sum;
  int unsigned     m_n;
  int unsigned     m_w[2] = '{40, 32};
  longint unsigned m_dout[2];
  bit              m_valid[2], m_sat[2], m_det[2], m_ovr[2];

  task automatic model_reset();
    m_sum = 0;
    m_n = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      m_dout[i] = 0; m_valid[i] = 0; m_sat[i] = 0; m_det[i] = 0; m_ovr[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit accept, fin;
    longint unsigned mx;
    accept = din_valid && en && !clear;
    fin = 0;
    if (clear) begin
      m_sum = 0;
      m_n = 0;
    end else if (accept) begin
      m_sum += longint'(din);
      m_n++;
      if (m_n == WL) fin = 1;
    end
    for (int unsigned i = 0; i < 2; i++) begin
      mx = (64'd1 << m_w[i]) - 1;
      if (clear) m_ovr[i] = 0;
      if (fin) begin
        if (m_valid[i] && !dout_ready) m_ovr[i] = 1;
        m_dout[i]  = (m_sum > mx) ? mx : m_sum;
        m_sat[i]   = m_sum > mx;
        m_det[i]   = m_dout[i] > TH;
        m_valid[i] = 1;
      end else if (m_valid[i] && dout_ready) begin
        m_valid[i] = 0;
      end
    end
    if (fin) begin
      m_sum = 0;
      m_n = 0;
    end
  endtask

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("A.dout", 64'(a_dout), m_dout[0]);
    chk("A.dout_valid", 64'(a_valid), 64'(m_valid[0]));
    chk("A.sat", 64'(a_sat), 64'(m_sat[0]));
    chk("A.detect", 64'(a_det), 64'(m_det[0]));
    chk("A.overrun", 64'(a_ovr), 64'(m_ovr[0]));
    chk("B.dout", 64'(b_dout), m_dout[1]);
    chk("B.dout_valid", 64'(b_valid), 64'(m_valid[1]));
    chk("B.sat", 64'(b_sat), 64'(m_sat[1]));
    chk("B.detect", 64'(b_det), 64'(m_det[1]));
    chk("B.overrun", 64'(b_ovr), 64'(m_ovr[1]));
  endtask

  // Inputs are set at the falling edge; the model steps at the rising edge
  // and outputs are compared at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input bit v, input logic [31:0] d);
    din_valid = v;
    din = d;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    logic [39:0] e_dout;
    bit          e_valid;
    bit          e_det;
    bit          e_sat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 32'd10, 40'd0,   0, 0, 0};
    tbl[1]  = '{1, 32'd20, 40'd0,   0, 0, 0};
    tbl[2]  = '{1, 32'd30, 40'd0,   0, 0, 0};
    tbl[3]  = '{1, 32'd40, 40'd100, 1, 0, 0};
    tbl[4]  = '{0, 32'd77, 40'd100, 0, 0, 0};
    tbl[5]  = '{1, 32'd50, 40'd100, 0, 0, 0};
    tbl[6]  = '{1, 32'd0,  40'd100, 0, 0, 0};
    tbl[7]  = '{0, 32'd99, 40'd100, 0, 0, 0};
    tbl[8]  = '{1, 32'd60, 40'd100, 0, 0, 0};
    tbl[9]  = '{1, 32'd1,  40'd111, 1, 1, 0};
    tbl[10] = '{0, 32'd0,  40'd111, 0, 1, 0};
    tbl[11] = '{0, 32'd0,  40'd111, 0, 1, 0};

    @(negedge clk);
    do_reset();

    // Basic windows, gaps not counted.
    for (int unsigned i = 0; i < 12; i++) begin
      send(tbl[i].v, tbl[i].d);
      chk("tbl.dout", 64'(a_dout), 64'(tbl[i].e_dout));
      chk("tbl.valid", 64'(a_valid), 64'(tbl[i].e_valid));
      chk("tbl.detect", 64'(a_det), 64'(tbl[i].e_det));
      chk("tbl.sat", 64'(a_sat), 64'(tbl[i].e_sat));
    end

    // Backpressure: second window overwrites an unconsumed result.
    dout_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) send(1, 32'd25);
    chk("bp.valid1", 64'(a_valid), 64'd1);
    chk("bp.ovr1", 64'(a_ovr), 64'd0);
    for (int unsigned i = 0; i < 3; i++) send(1, 32'd25);
    chk("bp.held", 64'(a_dout), 64'd100);
    send(1, 32'd25);
    chk("bp.ovr2", 64'(a_ovr), 64'd1);
    send(0, 32'd0);
    chk("bp.ovr_sticky", 64'(a_ovr), 64'd1);
    chk("bp.valid_held", 64'(a_valid), 64'd1);
    dout_ready = 1'b1;
    send(0, 32'd0);
    chk("bp.valid_drop", 64'(a_valid), 64'd0);

    // Pause with en low, then clear mid-window.
    send(1, 32'd5);
    send(1, 32'd5);
    en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) send(1, 32'd5);
    en = 1'b1;
    send(1, 32'd5);
    send(1, 32'd5);
    chk("en.dout", 64'(a_dout), 64'd20);
    send(1, 32'd7);
    send(1, 32'd7);
    clear = 1'b1;
    send(1, 32'd7);
    clear = 1'b0;
    chk("clr.ovr", 64'(a_ovr), 64'd0);
    for (int unsigned i = 0; i < 4; i++) send(1, 32'd1);
    chk("clr.dout", 64'(a_dout), 64'd4);

    // Saturation on the 32-bit build.
    for (int unsigned i = 0; i < 4; i++) send(1, 32'hFFFF_FFFF);
    chk("sat.b_dout", 64'(b_dout), 64'hFFFF_FFFF);
    chk("sat.b_sat", 64'(b_sat), 64'd1);
    chk("sat.a_dout", 64'(a_dout), 64'h3_FFFF_FFFC);
    chk("sat.a_sat", 64'(a_sat), 64'd0);
    for (int unsigned i = 0; i < 4; i++) send(1, 32'd1);
    chk("sat.b_next", 64'(b_dout), 64'd4);
    chk("sat.b_clr", 64'(b_sat), 64'd0);

    // Reset mid-window discards the partial sum.
    for (int unsigned i = 0; i < 3; i++) send(1, 32'd9);
    do_reset();
    chk("rst.dout", 64'(a_dout), 64'd0);
    for (int unsigned i = 0; i < 4; i++) send(1, 32'd1);
    chk("rst.next", 64'(a_dout), 64'd4);

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 600; i++) begin
      en         = ($urandom % 8) != 0;
      clear      = ($urandom % 32) == 0;
      dout_ready = ($urandom % 3) != 0;
      send(($urandom % 4) != 0, (($urandom % 4) == 0) ? $urandom : ($urandom % 60));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
